// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory bus. Data has priority.
// Response pulses two cycles after grant at best; a 256-cycle ack timeout completes with data 0 and sets bus_error.
module mem_arbiter (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fetch_enable,
    input  logic [31:0] PCfetch,
    output logic        fetch_valid,
    output logic [31:0] instr_fetch,
    input  logic        memory_en,
    input  logic [1:0]  store_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic        mem_read_data_valid,
    output logic [31:0] mem_read_data,
    output logic        mem_write_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        is_fetch_q, is_fetch_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [8:0]  tmo_q, tmo_d;
    logic        err_q, err_d;

    logic busy;
    logic resp;

    always_comb begin
        state_d    = state_q;
        is_fetch_d = is_fetch_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (memory_en) begin
                    state_d    = S_DATA;
                    is_fetch_d = 1'b0;
                    we_d       = (store_size != 2'b11);
                    size_d     = store_size;
                    addr_d     = mem_addr;
                    wdata_d    = mem_write_data;
                    tmo_d      = 9'd0;
                end else if (fetch_enable) begin
                    state_d    = S_FETCH;
                    is_fetch_d = 1'b1;
                    we_d       = 1'b0;
                    size_d     = 2'b10;
                    addr_d     = PCfetch;
                    wdata_d    = 32'd0;
                    tmo_d      = 9'd0;
                end
            end
            S_FETCH, S_DATA: begin
                if (bus_ack) begin
                    rdata_d = bus_rdata;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 9'd1;
                    // 256th cycle without ack: give up and complete with zero data
                    if (tmo_q == 9'd255) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_fetch_q <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            tmo_q      <= 9'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_fetch_q <= is_fetch_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q == S_FETCH) || (state_q == S_DATA);
    assign resp = (state_q == S_RESP);

    // Bus fields are zeroed outside a transaction so idle outputs match reset
    assign bus_req   = busy;
    assign bus_we    = busy & we_q;
    assign bus_size  = busy ? size_q  : 2'b00;
    assign bus_addr  = busy ? addr_q  : 32'd0;
    assign bus_wdata = busy ? wdata_q : 32'd0;

    assign fetch_valid         = resp & is_fetch_q;
    assign mem_read_data_valid = resp & ~is_fetch_q & ~we_q;
    assign mem_write_ready     = resp & ~is_fetch_q & we_q;
    assign instr_fetch         = fetch_valid ? rdata_q : 32'd0;
    assign mem_read_data       = mem_read_data_valid ? rdata_q : 32'd0;
    assign bus_error           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mem_arbiter;

    logic        CLK;
    logic        reset;
    logic        fetch_enable;
    logic [31:0] PCfetch;
    logic        fetch_valid;
    logic [31:0] instr_fetch;
    logic        memory_en;
    logic [1:0]  store_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read_data_valid;
    logic [31:0] mem_read_data;
    logic        mem_write_ready;
    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_error;

    mem_arbiter dut (
        .CLK                 (CLK),
        .reset               (reset),
        .fetch_enable        (fetch_enable),
        .PCfetch             (PCfetch),
        .fetch_valid         (fetch_valid),
        .instr_fetch         (instr_fetch),
        .memory_en           (memory_en),
        .store_size          (store_size),
        .mem_addr            (mem_addr),
        .mem_write_data      (mem_write_data),
        .mem_read_data_valid (mem_read_data_valid),
        .mem_read_data       (mem_read_data),
        .mem_write_ready     (mem_write_ready),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_size            (bus_size),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_ack             (bus_ack),
        .bus_rdata           (bus_rdata),
        .bus_error           (bus_error)
    );

    typedef struct {
        logic [1:0]  kind;   // 0 fetch, 1 read, 2 write
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic chk_bus(input string tag, input logic [31:0] addr, input logic we,
                           input logic [1:0] sz, input logic [31:0] wd);
        chk({tag, "_req"},  32'(bus_req), 32'd1);
        chk({tag, "_addr"}, bus_addr, addr);
        chk({tag, "_we"},   32'(bus_we), 32'(we));
        chk({tag, "_size"}, 32'(bus_size), 32'(sz));
        if (we) chk({tag, "_wdata"}, bus_wdata, wd);
    endtask

    // Monitor: every response pulse must match the oldest expected entry
    always @(negedge CLK) begin
        if (!reset) begin
            if (fetch_valid || mem_read_data_valid || mem_write_ready) begin
                chk("resp_onehot", 32'(fetch_valid) + 32'(mem_read_data_valid) + 32'(mem_write_ready), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp fv=%b rv=%b wr=%b required none at %0t",
                             fetch_valid, mem_read_data_valid, mem_write_ready, $time);
                end else begin
                    exp_t e;
                    logic [1:0] k;
                    e = exp_q.pop_front();
                    k = fetch_valid ? 2'd0 : (mem_read_data_valid ? 2'd1 : 2'd2);
                    chk("resp_kind", 32'(k), 32'(e.kind));
                    if (k == 2'd0) chk("instr_fetch", instr_fetch, e.data);
                    if (k == 2'd1) chk("mem_read_data", mem_read_data, e.data);
                end
            end
            if (!fetch_valid) chk("instr_fetch_zero", instr_fetch, 32'd0);
            if (!mem_read_data_valid) chk("mem_read_data_zero", mem_read_data, 32'd0);
        end
    end

    // Single transaction; request fields are scrambled after grant to prove they were registered
    task automatic txn(input logic is_fetch, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_we, input logic [1:0] exp_sz,
                       input int delay, input logic [31:0] rd, input logic hold);
        if (is_fetch) begin
            fetch_enable = 1'b1;
            PCfetch      = addr;
            push_exp(2'd0, rd);
        end else begin
            memory_en      = 1'b1;
            store_size     = sz;
            mem_addr       = addr;
            mem_write_data = wd;
            push_exp(exp_we ? 2'd2 : 2'd1, exp_we ? 32'd0 : rd);
        end
        cyc();
        if (!hold) begin
            fetch_enable = 1'b0;
            memory_en    = 1'b0;
        end
        PCfetch        = ~addr;
        mem_addr       = ~addr;
        mem_write_data = ~wd;
        for (int i = 0; i <= delay; i++) begin
            bus_ack   = (i == delay);
            bus_rdata = (i == delay) ? rd : (32'hBAD0_0000 + 32'(i));
            @(negedge CLK);
            chk_bus("txn", addr, exp_we, exp_sz, wd);
            cyc();
        end
        bus_ack   = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("txn_resp_req", 32'(bus_req), 32'd0);
        cyc();
        fetch_enable = 1'b0;
        memory_en    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; fetch_enable = 1'b0; PCfetch = 32'd0; memory_en = 1'b0;
        store_size = 2'b00; mem_addr = 32'd0; mem_write_data = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) cyc();
        @(negedge CLK);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_rd_valid", 32'(mem_read_data_valid), 32'd0);
        chk("rst_wr_ready", 32'(mem_write_ready), 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // Stray acks in IDLE must be ignored
        bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        repeat (2) begin
            @(negedge CLK);
            chk("idle_ack_req", 32'(bus_req), 32'd0);
            cyc();
        end
        bus_ack = 1'b0;

        // Fetch, ack on first cycle
        txn(1'b1, 2'b10, 32'h0000_0100, 32'd0, 1'b0, 2'b10, 0, 32'h0050_0093, 1'b0);

        // Simultaneous requests: data first, fetch bus_req two cycles after the write pulse
        memory_en = 1'b1; store_size = 2'b10; mem_addr = 32'h0000_2000; mem_write_data = 32'hDEAD_BEEF;
        fetch_enable = 1'b1; PCfetch = 32'h0000_0400;
        push_exp(2'd2, 32'd0);
        push_exp(2'd0, 32'h0000_0013);
        cyc();
        memory_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        @(negedge CLK);
        chk_bus("prio_data", 32'h0000_2000, 1'b1, 2'b10, 32'hDEAD_BEEF);
        cyc();
        bus_ack = 1'b0;
        @(negedge CLK); chk("prio_resp_req", 32'(bus_req), 32'd0);
        cyc();
        @(negedge CLK); chk("prio_gap_req", 32'(bus_req), 32'd0);
        cyc();
        fetch_enable = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
        @(negedge CLK);
        chk_bus("prio_fetch", 32'h0000_0400, 1'b0, 2'b10, 32'd0);
        cyc();
        bus_ack = 1'b0;
        @(negedge CLK); chk("prio_fetch_resp_req", 32'(bus_req), 32'd0);
        cyc();

        // Load with ack on the sixth bus_req cycle
        txn(1'b0, 2'b11, 32'h0000_3000, 32'h0000_0000, 1'b0, 2'b11, 5, 32'h1234_5678, 1'b0);
        // Byte and half stores
        txn(1'b0, 2'b00, 32'h0000_0041, 32'h0000_00AA, 1'b1, 2'b00, 1, 32'h5555_5555, 1'b0);
        txn(1'b0, 2'b01, 32'h0000_0042, 32'h0000_BEEF, 1'b1, 2'b01, 2, 32'h6666_6666, 1'b0);

        // Request held through the response: exactly one transaction
        txn(1'b0, 2'b11, 32'h0000_0044, 32'd0, 1'b0, 2'b11, 0, 32'hCAFE_F00D, 1'b1);
        repeat (2) begin
            @(negedge CLK);
            chk("hold_no_reissue", 32'(bus_req), 32'd0);
            cyc();
        end

        // Store arriving during a fetch waits for IDLE
        fetch_enable = 1'b1; PCfetch = 32'h0000_0200;
        push_exp(2'd0, 32'h0000_00A1);
        push_exp(2'd2, 32'd0);
        cyc();
        fetch_enable = 1'b0;
        memory_en = 1'b1; store_size = 2'b10; mem_addr = 32'h0000_0300; mem_write_data = 32'h0000_0055;
        @(negedge CLK); chk_bus("late_fetch0", 32'h0000_0200, 1'b0, 2'b10, 32'd0);
        cyc();
        bus_ack = 1'b1; bus_rdata = 32'h0000_00A1;
        @(negedge CLK); chk_bus("late_fetch1", 32'h0000_0200, 1'b0, 2'b10, 32'd0);
        cyc();
        bus_ack = 1'b0;
        @(negedge CLK); chk("late_resp_req", 32'(bus_req), 32'd0);
        cyc();
        @(negedge CLK); chk("late_idle_req", 32'(bus_req), 32'd0);
        cyc();
        memory_en = 1'b0; bus_ack = 1'b1;
        @(negedge CLK); chk_bus("late_store", 32'h0000_0300, 1'b1, 2'b10, 32'h0000_0055);
        cyc();
        bus_ack = 1'b0;
        cyc();
        cyc();

        // Timeout: no ack for 256 cycles
        memory_en = 1'b1; store_size = 2'b11; mem_addr = 32'h0000_5000;
        push_exp(2'd1, 32'd0);
        cyc();
        memory_en = 1'b0; bus_rdata = 32'hAAAA_5555;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            chk("tmo_req_high", 32'(bus_req), 32'd1);
            if (i == 255) chk("tmo_err_before", 32'(bus_error), 32'd0);
            cyc();
        end
        @(negedge CLK);
        chk("tmo_req_drop", 32'(bus_req), 32'd0);
        chk("tmo_err_set", 32'(bus_error), 32'd1);
        cyc();
        repeat (3) begin
            @(negedge CLK);
            chk("tmo_err_sticky", 32'(bus_error), 32'd1);
            cyc();
        end
        reset = 1'b1;
        cyc();
        @(negedge CLK);
        chk("tmo_err_reset", 32'(bus_error), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        // Reset during a DATA wait: no pulse, bus_req drops
        memory_en = 1'b1; store_size = 2'b10; mem_addr = 32'h0000_6000; mem_write_data = 32'h0000_0011;
        cyc();
        memory_en = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("mid_req_high", 32'(bus_req), 32'd1);
            cyc();
        end
        reset = 1'b1;
        cyc();
        @(negedge CLK);
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_err", 32'(bus_error), 32'd0);
        cyc();
        reset = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("mid_after_req", 32'(bus_req), 32'd0);
            cyc();
        end

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; ports are listed below with the clock and reset first.
REQ-002 The block SHALL have port CLK, input, 1 bit: clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port fetch_enable, input, 1 bit: instruction fetch request.
REQ-005 The block SHALL have port PCfetch, input, 32 bits: fetch address.
REQ-006 The block SHALL have port fetch_valid, output, 1 bit: one-cycle fetch response pulse.
REQ-007 The block SHALL have port instr_fetch, output, 32 bits: fetched instruction, valid while fetch_valid=1.
REQ-008 The block SHALL have port memory_en, input, 1 bit: data load/store request.
REQ-009 The block SHALL have port store_size, input, 2 bits: 00 byte write, 01 half write, 10 word write, 11 read.
REQ-010 The block SHALL have port mem_addr and port mem_write_data, input, 32 bits each: data address and write data.
REQ-011 The block SHALL have port mem_read_data_valid, output, 1 bit: one-cycle load response pulse.
REQ-012 The block SHALL have port mem_read_data, output, 32 bits: load data, valid while mem_read_data_valid=1.
REQ-013 The block SHALL have port mem_write_ready, output, 1 bit: one-cycle store completion pulse.
REQ-014 The block SHALL have downstream outputs bus_req (1 bit), bus_we (1 bit), bus_size (2 bits), bus_addr (32 bits), bus_wdata (32 bits).
REQ-015 The block SHALL have downstream inputs bus_ack (1 bit) and bus_rdata (32 bits).
REQ-016 The block SHALL have port bus_error, output, 1 bit: sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, DATA and RESP.
REQ-018 In IDLE the block SHALL grant memory_en over fetch_enable when both are high (fixed data priority).
REQ-019 On grant, the block SHALL register the address, size and write data, and enter FETCH or DATA on the next edge.
REQ-020 In FETCH/DATA, bus_req SHALL be 1 with registered fields stable until bus_ack is sampled high.
REQ-021 FETCH SHALL drive bus_we=0 and bus_size=10; DATA SHALL drive bus_we=1 for store_size 00/01/10, and bus_we=0 with bus_size=11 for a read.
REQ-022 On bus_ack=1 the block SHALL latch bus_rdata and enter RESP, with bus_req=0 from the next cycle.
REQ-023 In RESP, for exactly one cycle, the block SHALL assert fetch_valid (FETCH), mem_read_data_valid (DATA read) or mem_write_ready (DATA write), with latched data on the matching bus, then return to IDLE.
REQ-024 No grant SHALL occur in RESP, so a request still high from the completed requester is not re-issued.
REQ-025 Latency: request sampled in IDLE at cycle 0, bus_req at cycle 1, earliest ack at cycle 1, response pulse at cycle 2, next grant sampled at cycle 3.
REQ-026 A request deasserted mid-transaction SHALL NOT cancel it; the transaction completes and the response still pulses.
REQ-027 A request arriving on the other port during a transaction SHALL wait until IDLE.
REQ-028 A 9-bit timeout counter SHALL clear on grant and increment each FETCH/DATA cycle with bus_ack=0.
REQ-029 On the 256th consecutive cycle without ack, the block SHALL drop bus_req, enter RESP with response data 0, and set bus_error.
REQ-030 bus_error SHALL remain set until reset.
REQ-031 bus_ack received in IDLE or RESP SHALL be ignored.
REQ-032 Response data outputs SHALL be 0 whenever their valid pulse is 0.

Reset
REQ-033 While reset=1 at a rising edge, the block SHALL set state=IDLE, the counter to 0, and all outputs to 0, including bus_error.
REQ-034 Reset asserted mid-transaction SHALL drop bus_req at that edge with no response pulse.

Verification
REQ-035 Fetch only, PCfetch=0x100, bus_ack on the first bus_req cycle with bus_rdata=0x00500093 -> bus_addr=0x100 and bus_we=0 at cycle 1, then fetch_valid=1 and instr_fetch=0x00500093 at cycle 2.
REQ-036 fetch_enable and memory_en high together, store_size=10, mem_addr=0x2000, mem_write_data=0xDEADBEEF -> DATA granted first with bus_we=1, mem_write_ready pulse, then the fetch bus_req starts 2 cycles after that pulse.
REQ-037 Load with store_size=11, bus_ack delayed 5 cycles, bus_rdata=0x12345678 -> bus_req high 6 cycles with stable fields, then one mem_read_data_valid pulse with 0x12345678.
REQ-038 memory_en held high through the response cycle -> exactly one bus transaction.
REQ-039 bus_ack never asserted -> bus_req drops after 256 cycles, one response pulse with data 0, bus_error=1 until reset.
REQ-040 Reset asserted during a DATA wait -> bus_req=0 the next cycle, no response pulse, bus_error=0.
